ysyx_040729_id_exe_pipe: RTL and testbench

- Pipeline register between decode and the EXE ALU.
- Captures decoded operands and ALU control, and presents them to the ALU with a valid/ready handshake.
- Uses a two-entry skid buffer so that `in_ready` is a registered signal.
- Held entries snoop a writeback forwarding bus, so stalled operands never go stale.

---
 rtl/ysyx_040729_id_exe_pipe.sv | 144 ++++++++++++++
 tb/tb_ysyx_040729_id_exe_pipe.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_040729_id_exe_pipe.sv
// Decode-to-EXE pipeline register: a two-entry skid buffer with a registered in_ready.
// Held entries snoop the writeback bus so that stalled operands stay current.
module ysyx_040729_id_exe_pipe #(
    parameter int DATA_WIDTH = 64,
    parameter int REG_AW     = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_src1,
    input  logic [DATA_WIDTH-1:0] in_src2,
    input  logic [REG_AW-1:0]     in_rs1,
    input  logic [REG_AW-1:0]     in_rs2,
    input  logic                  in_rs1_en,
    input  logic                  in_rs2_en,
    input  logic [REG_AW-1:0]     in_rd,
    input  logic [2:0]            in_alu_func3,
    input  logic [6:0]            in_alu_func7,
    input  logic                  in_alu_src2_ri,
    input  logic                  in_alu_len_dw,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_src1,
    output logic [DATA_WIDTH-1:0] out_src2,
    output logic [REG_AW-1:0]     out_rd,
    output logic [2:0]            out_alu_func3,
    output logic [6:0]            out_alu_func7,
    output logic                  out_alu_src2_ri,
    output logic                  out_alu_len_dw,
    input  logic                  fwd_valid,
    input  logic [REG_AW-1:0]     fwd_rd,
    input  logic [DATA_WIDTH-1:0] fwd_data
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] src1;
        logic [DATA_WIDTH-1:0] src2;
        logic [REG_AW-1:0]     rs1;
        logic [REG_AW-1:0]     rs2;
        logic                  rs1_en;
        logic                  rs2_en;
        logic [REG_AW-1:0]     rd;
        logic [2:0]            func3;
        logic [6:0]            func7;
        logic                  src2_ri;
        logic                  len_dw;
    } entry_t;

    entry_t r_main;
    entry_t r_skid;
    logic   r_main_valid;
    logic   r_skid_valid;

    entry_t w_main_next;
    entry_t w_skid_next;
    entry_t w_in_entry;
    logic   w_main_valid_next;
    logic   w_skid_valid_next;
    logic   w_accept;
    logic   w_drain;

    // Register x0 is hardwired to zero, so it is never forwarded.
    function automatic entry_t snoop(input entry_t e, input logic v, input logic [REG_AW-1:0] rd,
                                     input logic [DATA_WIDTH-1:0] data);
        entry_t r;
        r = e;
        if (v && (rd != '0)) begin
            if (e.rs1_en && (e.rs1 == rd)) r.src1 = data;
            if (e.rs2_en && (e.rs2 == rd)) r.src2 = data;
        end
        return r;
    endfunction

    assign in_ready = !r_skid_valid;
    assign w_accept = in_valid && !r_skid_valid;
    assign w_drain  = r_main_valid && out_ready;

    always_comb begin
        w_in_entry = '{
            src1:    in_src1,
            src2:    in_src2,
            rs1:     in_rs1,
            rs2:     in_rs2,
            rs1_en:  in_rs1_en,
            rs2_en:  in_rs2_en,
            rd:      in_rd,
            func3:   in_alu_func3,
            func7:   in_alu_func7,
            src2_ri: in_alu_src2_ri,
            len_dw:  in_alu_len_dw
        };
        w_in_entry = snoop(w_in_entry, fwd_valid, fwd_rd, fwd_data);
    end

    always_comb begin
        w_main_next       = r_main_valid ? snoop(r_main, fwd_valid, fwd_rd, fwd_data) : r_main;
        w_skid_next       = r_skid_valid ? snoop(r_skid, fwd_valid, fwd_rd, fwd_data) : r_skid;
        w_main_valid_next = r_main_valid;
        w_skid_valid_next = r_skid_valid;
        if (flush) begin
            w_main_valid_next = 1'b0;
            w_skid_valid_next = 1'b0;
        end else if (!r_main_valid || (w_drain && !r_skid_valid)) begin
            w_main_valid_next = w_accept;
            if (w_accept) w_main_next = w_in_entry;
        end else if (!w_drain) begin
            if (w_accept) begin
                w_skid_valid_next = 1'b1;
                w_skid_next       = w_in_entry;
            end
        end else begin
            // MAIN drains while SKID is full: the snooped SKID entry moves up.
            w_main_next       = w_skid_next;
            w_main_valid_next = 1'b1;
            w_skid_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main       <= '0;
            r_skid       <= '0;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else begin
            r_main       <= w_main_next;
            r_skid       <= w_skid_next;
            r_main_valid <= w_main_valid_next;
            r_skid_valid <= w_skid_valid_next;
        end
    end

    assign out_valid       = r_main_valid;
    assign out_src1        = r_main.src1;
    assign out_src2        = r_main.src2;
    assign out_rd          = r_main.rd;
    assign out_alu_func3   = r_main.func3;
    assign out_alu_func7   = r_main.func7;
    assign out_alu_src2_ri = r_main.src2_ri;
    assign out_alu_len_dw  = r_main.len_dw;

endmodule

// File: tb/tb_ysyx_040729_id_exe_pipe.sv
// Directed bench for ysyx_040729_id_exe_pipe: handshake ordering, skid, forwarding, flush and async reset.
module tb_ysyx_040729_id_exe_pipe;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_src1;
    logic [63:0] in_src2;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic        in_rs1_en;
    logic        in_rs2_en;
    logic [4:0]  in_rd;
    logic [2:0]  in_alu_func3;
    logic [6:0]  in_alu_func7;
    logic        in_alu_src2_ri;
    logic        in_alu_len_dw;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_src1;
    logic [63:0] out_src2;
    logic [4:0]  out_rd;
    logic [2:0]  out_alu_func3;
    logic [6:0]  out_alu_func7;
    logic        out_alu_src2_ri;
    logic        out_alu_len_dw;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [63:0] fwd_data;

    int total = 0;
    int bad   = 0;

    ysyx_040729_id_exe_pipe #(.DATA_WIDTH(64), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_src1(in_src1), .in_src2(in_src2),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_rs1_en(in_rs1_en), .in_rs2_en(in_rs2_en),
        .in_rd(in_rd), .in_alu_func3(in_alu_func3), .in_alu_func7(in_alu_func7),
        .in_alu_src2_ri(in_alu_src2_ri), .in_alu_len_dw(in_alu_len_dw),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_src1(out_src1), .out_src2(out_src2), .out_rd(out_rd),
        .out_alu_func3(out_alu_func3), .out_alu_func7(out_alu_func7),
        .out_alu_src2_ri(out_alu_src2_ri), .out_alu_len_dw(out_alu_len_dw),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [63:0] s1, input logic [63:0] s2,
                                 input logic [4:0] rs1, input logic rs1_en,
                                 input logic [4:0] rs2, input logic rs2_en, input logic [4:0] rd);
        in_valid  = v;
        in_src1   = s1;
        in_src2   = s2;
        in_rs1    = rs1;
        in_rs1_en = rs1_en;
        in_rs2    = rs2;
        in_rs2_en = rs2_en;
        in_rd     = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        fwd_valid = 1'b0; fwd_rd = '0; fwd_data = '0;
        in_alu_func3 = 3'b000; in_alu_func7 = 7'h00; in_alu_src2_ri = 1'b0; in_alu_len_dw = 1'b0;
        applyStimulus(1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        #12;
        checkOutput("rst_out_valid", {63'b0, out_valid}, 64'd0);
        checkOutput("rst_in_ready", {63'b0, in_ready}, 64'd1);
        checkOutput("rst_out_src1", out_src1, 64'd0);
        checkOutput("rst_out_rd", {59'b0, out_rd}, 64'd0);
        rst_n = 1'b1;
        tick();

        // Single transfer, zero-bubble latency
        out_ready = 1'b1;
        in_alu_func7 = 7'h20; in_alu_len_dw = 1'b1;
        applyStimulus(1'b1, 64'h5, 64'h7, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9);
        checkOutput("t1_in_ready_before", {63'b0, in_ready}, 64'd1);
        tick();
        checkOutput("t1_out_valid", {63'b0, out_valid}, 64'd1);
        checkOutput("t1_out_src1", out_src1, 64'h5);
        checkOutput("t1_out_src2", out_src2, 64'h7);
        checkOutput("t1_out_rd", {59'b0, out_rd}, 64'd9);
        checkOutput("t1_out_func7", {57'b0, out_alu_func7}, 64'h20);
        checkOutput("t1_out_len_dw", {63'b0, out_alu_len_dw}, 64'd1);
        checkOutput("t1_in_ready", {63'b0, in_ready}, 64'd1);
        in_alu_func7 = 7'h00; in_alu_len_dw = 1'b0;
        in_valid = 1'b0;
        tick();
        checkOutput("t1_drained", {63'b0, out_valid}, 64'd0);

        // Back-to-back stream of four
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 64'h100 + 64'(i), 64'h200 + 64'(i), 5'd0, 1'b0, 5'd0, 1'b0, 5'(i + 1));
            tick();
            checkOutput("t2_out_valid", {63'b0, out_valid}, 64'd1);
            checkOutput("t2_out_src1", out_src1, 64'h100 + 64'(i));
            checkOutput("t2_in_ready", {63'b0, in_ready}, 64'd1);
        end
        in_valid = 1'b0;
        tick();
        checkOutput("t2_drained", {63'b0, out_valid}, 64'd0);

        // Backpressure: A in MAIN, B in SKID, C held
        out_ready = 1'b0;
        applyStimulus(1'b1, 64'hA1, 64'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1);
        tick();
        checkOutput("t3_a_in_ready", {63'b0, in_ready}, 64'd1);
        applyStimulus(1'b1, 64'hB2, 64'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2);
        tick();
        checkOutput("t3_b_in_ready", {63'b0, in_ready}, 64'd0);
        checkOutput("t3_b_out_src1", out_src1, 64'hA1);
        applyStimulus(1'b1, 64'hC3, 64'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3);
        tick();
        checkOutput("t3_c_held_ready", {63'b0, in_ready}, 64'd0);
        checkOutput("t3_c_held_out", out_src1, 64'hA1);
        out_ready = 1'b1;
        tick();
        checkOutput("t3_out_b", out_src1, 64'hB2);
        checkOutput("t3_ready_after_move", {63'b0, in_ready}, 64'd1);
        tick();
        checkOutput("t3_out_c", out_src1, 64'hC3);
        checkOutput("t3_out_c_valid", {63'b0, out_valid}, 64'd1);
        in_valid = 1'b0;
        tick();
        checkOutput("t3_drained", {63'b0, out_valid}, 64'd0);

        // Forwarding into a held MAIN entry
        out_ready = 1'b0;
        applyStimulus(1'b1, 64'h10, 64'h20, 5'd3, 1'b1, 5'd5, 1'b0, 5'd7);
        tick();
        in_valid = 1'b0;
        checkOutput("t4_held_src1", out_src1, 64'h10);
        fwd_valid = 1'b1; fwd_rd = 5'd3; fwd_data = 64'hABCD;
        tick();
        checkOutput("t4_fwd_src1", out_src1, 64'hABCD);
        fwd_rd = 5'd5; fwd_data = 64'h7777;
        tick();
        checkOutput("t4_rs2_disabled", out_src2, 64'h20);
        checkOutput("t4_src1_stable", out_src1, 64'hABCD);
        fwd_rd = 5'd0; fwd_data = 64'h5555;
        tick();
        checkOutput("t4_rd0_src1", out_src1, 64'hABCD);
        fwd_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Index 0 never forwarded even when rs1 is 0; capture-time hit on rs2
        fwd_valid = 1'b1; fwd_rd = 5'd0; fwd_data = 64'h6666;
        applyStimulus(1'b1, 64'h30, 64'h40, 5'd0, 1'b1, 5'd0, 1'b1, 5'd4);
        tick();
        checkOutput("t4_x0_src1", out_src1, 64'h30);
        fwd_rd = 5'd9; fwd_data = 64'h99;
        applyStimulus(1'b1, 64'h50, 64'h60, 5'd4, 1'b1, 5'd9, 1'b1, 5'd6);
        tick();
        in_valid = 1'b0;
        // SKID entry snooped while held, then carried into MAIN
        fwd_rd = 5'd4; fwd_data = 64'h4444;
        tick();
        fwd_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        checkOutput("t4_skid_capture_src2", out_src2, 64'h99);
        checkOutput("t4_skid_snoop_src1", out_src1, 64'h4444);
        tick();
        checkOutput("t4_drained", {63'b0, out_valid}, 64'd0);

        // Flush with both entries full and an offered entry
        out_ready = 1'b0;
        applyStimulus(1'b1, 64'hD1, 64'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1);
        tick();
        applyStimulus(1'b1, 64'hD2, 64'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2);
        tick();
        checkOutput("t5_full_ready", {63'b0, in_ready}, 64'd0);
        applyStimulus(1'b1, 64'hEE, 64'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3);
        flush = 1'b1;
        tick();
        checkOutput("t5_flush_valid", {63'b0, out_valid}, 64'd0);
        checkOutput("t5_flush_ready", {63'b0, in_ready}, 64'd1);
        tick();
        checkOutput("t5_flush_accept_dropped", {63'b0, out_valid}, 64'd0);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        checkOutput("t5_nothing_appears", {63'b0, out_valid}, 64'd0);

        // Asynchronous reset while two entries are held
        out_ready = 1'b0;
        applyStimulus(1'b1, 64'hF1, 64'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1);
        tick();
        applyStimulus(1'b1, 64'hF2, 64'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2);
        tick();
        in_valid = 1'b0;
        checkOutput("t6_pre_valid", {63'b0, out_valid}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_async_valid", {63'b0, out_valid}, 64'd0);
        checkOutput("t6_async_src1", out_src1, 64'd0);
        #4;
        rst_n = 1'b1;
        tick();
        checkOutput("t6_release_ready", {63'b0, in_ready}, 64'd1);
        checkOutput("t6_release_valid", {63'b0, out_valid}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
